// File: rtl/subbytes_seq.sv
// -----------------------------------------------------------------------------
// subbytes_seq
//   Sequencer for one AES SubBytes stage that owns a 256x8 1W/1R S-box macro.
//   The macro has active-low chip selects and registers its address.
//
//   After reset it streams the 256 S-box entries into the macro write port.
//   It then takes 128-bit states one at a time and issues 16 byte lookups on
//   the read port. It returns the substituted state downstream through a
//   valid/ready handshake.
//
//   Optional build macro: SBOX_RELOAD_EN
//     Adds the input `reload`. A reload request seen in IDLE rewrites the
//     S-box table. A request seen in RUN/OUT is held until the next IDLE.
//
// Ports
//   clk, rst_n           single clock (also the macro clock), async active-low reset
//   reload               (SBOX_RELOAD_EN only) request a new S-box table
//   ld_valid/ld_byte     S-box load stream, one entry per accepted beat
//   ld_ready             high while loading
//   init_done            all 256 entries written
//   in_valid/in_ready    input state handshake; in_state byte i = [127-8i -: 8]
//   in_state             128-bit state to substitute
//   out_valid/out_ready  output state handshake
//   out_state            substituted state, same byte order as in_state
//   sram_csb0/addr0/din0 macro write port (csb active low)
//   sram_csb1/addr1      macro read port (csb active low)
//   sram_dout1           macro read data, valid the cycle after address capture
// -----------------------------------------------------------------------------
module subbytes_seq #(
    parameter int NBYTES = 16,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef SBOX_RELOAD_EN
    input  logic                   reload,
`endif
    input  logic                   ld_valid,
    input  logic [DW-1:0]          ld_byte,
    output logic                   ld_ready,
    output logic                   init_done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBYTES*DW-1:0]   in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBYTES*DW-1:0]   out_state,
    output logic                   sram_csb0,
    output logic [AW-1:0]          sram_addr0,
    output logic [DW-1:0]          sram_din0,
    output logic                   sram_csb1,
    output logic [AW-1:0]          sram_addr1,
    input  logic [DW-1:0]          sram_dout1
);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN, S_OUT} state_t;

    state_t                state, state_nx;
    logic [AW-1:0]         wr_cnt;
    logic [4:0]            rd_cnt;     // 0..15 issue lookups, 16 drains the last read
    logic [NBYTES*DW-1:0]  st_reg;
    logic [3:0]            rd_idx;     // byte being looked up this cycle
    logic [3:0]            wb_idx;     // byte whose read data arrives this cycle
    logic                  reload_req;
    logic                  accept;

    assign rd_idx = rd_cnt[3:0];
    assign wb_idx = rd_idx - 4'd1;     // rd_cnt=16 wraps to byte 15
    assign accept = (state == S_IDLE) && in_valid && !reload_req;

`ifdef SBOX_RELOAD_EN
    // A request that arrives while a block is in flight is held until IDLE.
    logic reload_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_pend <= 1'b0;
        end else if (state == S_IDLE) begin
            reload_pend <= 1'b0;
        end else if ((state == S_RUN || state == S_OUT) && reload) begin
            reload_pend <= 1'b1;
        end
    end

    assign reload_req = reload | reload_pend;
`else
    assign reload_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples the pre-edge values of the others.
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        // NOTE: give every always_comb output a default first, so no path can
        // leave it unassigned and infer a latch.
        state_nx = state;
        unique case (state)
            S_LOAD:  if (ld_valid && wr_cnt == '1) state_nx = S_IDLE;
            S_IDLE: begin
                if (reload_req)    state_nx = S_LOAD;
                else if (in_valid) state_nx = S_RUN;
            end
            S_RUN:   if (rd_cnt == 5'd16) state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_LOAD;
        endcase
    end

    // Output logic: macro controls are combinational and are registered
    // inside the macro on the same clock edge.
    always_comb begin
        ld_ready   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sram_csb0  = 1'b1;
        sram_csb1  = 1'b1;
        sram_addr0 = wr_cnt;
        sram_din0  = ld_byte;
        sram_addr1 = st_reg[{~rd_idx, 3'b000} +: DW];
        unique case (state)
            S_LOAD: begin
                ld_ready  = 1'b1;
                sram_csb0 = ~ld_valid;
            end
            S_IDLE:  in_ready  = ~reload_req;
            S_RUN:   sram_csb1 = rd_cnt[4];   // no lookup in the drain cycle
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // Counters, init flag and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            init_done <= 1'b0;
            out_state <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (ld_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == '1) init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (reload_req) begin
                        wr_cnt    <= '0;
                        init_done <= 1'b0;
                    end else if (in_valid) begin
                        rd_cnt <= '0;
                    end
                end
                S_RUN: begin
                    rd_cnt <= rd_cnt + 5'd1;
                    // Read data lags the issued address by one cycle.
                    if (rd_cnt != 5'd0) out_state[{~wb_idx, 3'b000} +: DW] <= sram_dout1;
                end
                default: ;
            endcase
        end
    end

    // Input state capture
    always_ff @(posedge clk) begin
        // NOTE: pure datapath register that is always written before it is
        // read, so it carries no reset.
        if (accept) st_reg <= in_state;
    end

endmodule

// File: tb/tb_subbytes_seq.sv
// -----------------------------------------------------------------------------
// tb_subbytes_seq
//   Self-checking bench for subbytes_seq. It provides a behavioural model of the
//   S-box macro and a table-lookup reference for SubBytes. One compare process
//   checks out_valid/out_state on every cycle in which they matter. Directed
//   literal vectors pin the reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ld_valid = 1'b0;
    logic [7:0]   ld_byte = 8'h00;
    logic         ld_ready, init_done;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         sram_csb0, sram_csb1;
    logic [7:0]   sram_addr0, sram_din0, sram_addr1, sram_dout1;
`ifdef SBOX_RELOAD_EN
    logic         reload = 1'b0;
`endif

    always #5 clk = ~clk;

    subbytes_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SBOX_RELOAD_EN
        .reload     (reload),
`endif
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .init_done  (init_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    // S-box macro model: write and read addresses are captured on the clock edge.
    logic [7:0] sram_mem [256];
    always @(posedge clk) begin
        if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
    end

    // Reference tables
    logic [7:0] sbox_tbl  [256];
    logic [7:0] inv_tbl   [256];
    logic [7:0] model_tbl [256];   // table most recently loaded into the DUT

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [127:0] sub_model(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = model_tbl[s[127-8*i -: 8]];
        return r;
    endfunction

    // Scoreboard: every accepted state must show up 18 cycles later and stay
    // stable until downstream takes it.
    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back('{sub_model(in_state), cyc + 18});
            if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
                check("out_valid_on_time", {127'd0, out_valid}, 128'd1);
                check("out_state_model", out_state, exp_q[0].data);
            end else if (out_valid) begin
                if (exp_q.size() == 0 || cyc < exp_q[0].due)
                    check("out_valid_unexpected", {127'd0, out_valid}, 128'd0);
                else
                    check("out_state_hold", out_state, exp_q[0].data);
            end
            if (out_valid && out_ready && exp_q.size() > 0 && cyc >= exp_q[0].due)
                void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ld_ready"},  {127'd0, ld_ready},  128'd1);
        check({tag, "_in_ready"},  {127'd0, in_ready},  128'd0);
        check({tag, "_init_done"}, {127'd0, init_done}, 128'd0);
        check({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
        check({tag, "_out_state"}, out_state, 128'd0);
        check({tag, "_csb0"},      {127'd0, sram_csb0}, 128'd1);
        check({tag, "_csb1"},      {127'd0, sram_csb1}, 128'd1);
    endtask

    // Stream a full table. With gaps=1 ld_valid drops about half the time.
    task automatic load_table(input bit inv, input bit gaps);
        int idx, bad, first_cyc, guard, diffs;
        bit got_first;
        idx = 0; bad = 0; first_cyc = 0; guard = 0; diffs = 0; got_first = 0;
        for (int i = 0; i < 256; i++) model_tbl[i] = inv ? inv_tbl[i] : sbox_tbl[i];
        while (idx < 256 && guard < 2000) begin
            tick();
            ld_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            ld_byte  = model_tbl[idx];
            @(negedge clk);
            if (ld_valid) begin
                if (!got_first) begin
                    first_cyc = cyc;
                    got_first = 1;
                end
                if (sram_csb0 !== 1'b0 || sram_addr0 !== idx[7:0] ||
                    sram_din0 !== model_tbl[idx] || init_done !== 1'b0 || ld_ready !== 1'b1)
                    bad++;
                idx++;
            end else if (sram_csb0 !== 1'b1) begin
                bad++;
            end
            guard++;
        end
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        check("load_beats_complete", idx, 256);
        check("load_beat_errors", bad, 0);
        check("init_done_after_load", {127'd0, init_done}, 128'd1);
        check("ld_ready_after_load", {127'd0, ld_ready}, 128'd0);
        check("in_ready_after_load", {127'd0, in_ready}, 128'd1);
        if (!gaps) check("init_done_cycle", cyc - first_cyc + 1, 257);
        for (int i = 0; i < 256; i++) if (sram_mem[i] !== model_tbl[i]) diffs++;
        check("sram_table_contents", diffs, 0);
    endtask

    // Present a state and wait for acceptance; returns in the cycle after it.
    task automatic send_block(input logic [127:0] s, output int acc_cyc);
        bit done;
        done = 0;
        acc_cyc = 0;
        tick();
        in_state = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                done = 1;
            end else begin
                tick();
            end
        end
        if (!done) timeout_fail("send_block");
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int v_cyc);
        bit done;
        done = 0;
        v_cyc = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (out_valid) begin
                v_cyc = cyc;
                done = 1;
            end
        end
        if (!done) timeout_fail("wait_out");
    endtask

    localparam logic [127:0] VEC_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SUB_A = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] VEC_C = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    initial begin
        logic [2047:0] sbox_flat;
        int acc, v, acc_c;
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_flat[2047-8*i -: 8];
        for (int i = 0; i < 256; i++) inv_tbl[sbox_tbl[i]] = i[7:0];
        for (int i = 0; i < 256; i++) model_tbl[i] = sbox_tbl[i];

        // Reset values, observed while rst_n is low and before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Gap-free load of the forward S-box.
        load_table(1'b0, 1'b0);

        // ld_valid after init_done is ignored.
        tick();
        ld_valid = 1'b1;
        @(negedge clk);
        check("ld_after_init_csb0", {127'd0, sram_csb0}, 128'd1);
        check("ld_after_init_ready", {127'd0, ld_ready}, 128'd0);
        tick();
        ld_valid = 1'b0;

        // Block A: out_ready already high gives a single-cycle out_valid pulse.
        out_ready = 1'b1;
        send_block(VEC_A, acc);
        wait_out(v);
        check("latency_a", v - acc, 18);
        check("out_state_a", out_state, SUB_A);
        @(negedge clk);
        check("out_valid_pulse_a", {127'd0, out_valid}, 128'd0);

        // Block B: all-zero state with downstream stalled. The next state is
        // already offered during RUN/OUT and must wait for IDLE.
        out_ready = 1'b0;
        send_block('0, acc);
        in_state = VEC_C;
        in_valid = 1'b1;
        wait_out(v);
        check("latency_b", v - acc, 18);
        check("out_state_b", out_state, {16{8'h63}});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            check("stall_out_valid", {127'd0, out_valid}, 128'd1);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("idle_after_out_ready", {127'd0, in_ready}, 128'd1);
        acc_c = cyc;
        tick();
        in_valid = 1'b0;
        wait_out(v);
        check("latency_c", v - acc_c, 18);

        // Reset, then reload with random gaps: same table, same answer.
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        load_table(1'b0, 1'b1);
        send_block(VEC_A, acc);
        wait_out(v);
        check("out_state_a_gapped", out_state, SUB_A);

`ifdef SBOX_RELOAD_EN
        // reload wins over a simultaneous in_valid in IDLE.
        tick();
        reload   = 1'b1;
        in_valid = 1'b1;
        in_state = 128'hdeadbeef0123456789abcdeffedcba98;
        @(negedge clk);
        check("reload_priority_in_ready", {127'd0, in_ready}, 128'd0);
        tick();
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reload_ld_ready", {127'd0, ld_ready}, 128'd1);
        check("reload_init_done", {127'd0, init_done}, 128'd0);
        load_table(1'b1, 1'b0);
        send_block(SUB_A, acc);
        reload = 1'b1;   // lands in RUN, so it must be deferred
        tick();
        reload = 1'b0;
        wait_out(v);
        check("latency_inv", v - acc, 18);
        check("out_state_inv", out_state, VEC_A);
        @(negedge clk);
        check("deferred_reload_in_ready", {127'd0, in_ready}, 128'd0);
        @(negedge clk);
        check("deferred_reload_ld_ready", {127'd0, ld_ready}, 128'd1);
        check("deferred_reload_init_done", {127'd0, init_done}, 128'd0);
        load_table(1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of RUN (rd_cnt = 7).
        out_ready = 1'b1;
        send_block(VEC_A, acc);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("no_ready_without_load", {127'd0, in_ready}, 128'd0);
        check("ld_ready_after_midrun", {127'd0, ld_ready}, 128'd1);
        load_table(1'b0, 1'b0);
        send_block(VEC_A, acc);
        wait_out(v);
        check("out_state_a_after_reset", out_state, SUB_A);

        repeat (3) tick();
        check("model_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
